// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - default constants and FSM state encoding for the oversampled UART receiver
package uart_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 10;
    localparam int DEF_STOP_BITS    = 1;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;
    localparam uart_state_t ST_BREAK  = 3'd5;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for the serial line, resets to the idle (high) level
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - UART receiver with mid-bit sampling and a one-word valid/ready output register
// Optional parity checking is compiled in with macro UART_RX_PARITY_EN.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = DEF_STOP_BITS,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              parity_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_W - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 4 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_ovs: parameter out of legal range");
    end

    logic              w_rx;
    logic              w_tick;
    logic              w_par_ok;
    logic              w_last_stop_good;
    logic              w_complete;
    uart_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx_i),
        .o_q (w_rx)
    );

    // START resamples at half a bit; every later state samples a full bit after the previous sample.
    assign w_tick           = (r_state == ST_START) ? (r_cnt == CNT_HALF) : (r_cnt == CNT_LAST);
    assign w_last_stop_good = (r_state == ST_STOP) && w_tick && w_rx && (r_bit == STOP_LAST);
    assign w_complete       = w_last_stop_good && w_par_ok;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;

    assign w_par_ok     = !r_par_bad;
    assign parity_err_o = r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_last_stop_good && r_par_bad;
            if (r_state == ST_PARITY && w_tick) begin
                r_par_bad <= w_rx ^ (^r_shift) ^ (PARITY_ODD != 0);
            end
        end
    end
`else
    assign w_par_ok     = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (!w_rx) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_state <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[DATA_W-1:1]};
                        if (r_bit == BIT_LAST) begin
                            r_bit <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_frame_err <= 1'b1;
                            r_bit       <= '0;
                            r_state     <= ST_BREAK;
                        end else if (r_bit == STOP_LAST) begin
                            r_bit   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (w_rx) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A held word is never overwritten; a same-edge handshake frees the slot for the new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete && r_valid && !ready_i) begin
                r_overrun <= 1'b1;
            end else if (w_complete) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - directed bench with a frame-level expectation queue for uart_rx_ovs
module tb_uart_rx_ovs;

    localparam int DW      = 8;
    localparam int CPB     = 10;
    localparam int NSTOP   = 1;
    localparam int PAR_ODD = 0;

    localparam int EV_GOOD  = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_OVR   = 2;
    localparam int EV_PAR   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_i;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          frame_err_o;
    logic          overrun_o;
    logic          parity_err_o;

    int total = 0;
    int bad   = 0;

    int            q_kind[$];
    logic [DW-1:0] q_data[$];
    bit            m_held = 1'b0;

    int n_valid_cycles = 0;
    int n_events       = 0;
    int n_ferr         = 0;
    int n_ovr          = 0;
    int n_perr         = 0;

    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic          p_ferr  = 1'b0;
    logic          p_ovr   = 1'b0;
    logic          p_perr  = 1'b0;
    logic [DW-1:0] p_data  = '0;

    uart_rx_ovs dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic take_event(input int kind, input logic [DW-1:0] d);
        int            k;
        logic [DW-1:0] ed;
        n_events++;
        if (q_kind.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected no event", kind, d);
        end else begin
            k  = q_kind.pop_front();
            ed = q_data.pop_front();
            check("event_kind", kind, k);
            if (k == EV_GOOD && kind == EV_GOOD) check("event_data", int'(d), int'(ed));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_ferr  = 1'b0;
            p_ovr   = 1'b0;
            p_perr  = 1'b0;
            p_data  = '0;
        end else begin
            if (valid_o) n_valid_cycles++;
            if (p_valid && !p_ready) begin
                check("hold_valid", int'(valid_o), 1);
                check("hold_data", int'(data_o), int'(p_data));
            end
            if (valid_o && (!p_valid || p_ready)) take_event(EV_GOOD, data_o);
            if (frame_err_o) begin
                n_ferr++;
                check("frame_err_width", int'(p_ferr), 0);
                take_event(EV_FRAME, '0);
            end
            if (overrun_o) begin
                n_ovr++;
                check("overrun_width", int'(p_ovr), 0);
                take_event(EV_OVR, '0);
            end
            if (parity_err_o) begin
                n_perr++;
                check("parity_err_width", int'(p_perr), 0);
                take_event(EV_PAR, '0);
            end
            p_valid = valid_o;
            p_ready = ready_i;
            p_ferr  = frame_err_o;
            p_ovr   = overrun_o;
            p_perr  = parity_err_o;
            p_data  = data_o;
        end
    end

    function automatic logic par_of(input logic [DW-1:0] d);
        return (^d) ^ (PAR_ODD != 0);
    endfunction

    // Frame-level outcome: stop error beats parity error beats overrun.
    task automatic model_frame(input logic [DW-1:0] d, input logic par_bit, input logic stop_v);
        bit par_bad;
`ifdef UART_RX_PARITY_EN
        par_bad = (par_bit != par_of(d));
`else
        par_bad = 1'b0;
`endif
        if (!stop_v) begin
            q_kind.push_back(EV_FRAME);
            q_data.push_back('0);
        end else if (par_bad) begin
            q_kind.push_back(EV_PAR);
            q_data.push_back('0);
        end else if (m_held && !ready_i) begin
            q_kind.push_back(EV_OVR);
            q_data.push_back('0);
        end else begin
            q_kind.push_back(EV_GOOD);
            q_data.push_back(d);
            if (!ready_i) m_held = 1'b1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par_bit, input logic stop_v,
                              input int gap_bits);
        model_frame(d, par_bit, stop_v);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`endif
        for (int s = 0; s < NSTOP; s++) send_bit(stop_v);
        rx_i = 1'b1;
        for (int c = 0; c < 4 * CPB && q_kind.size() != 0; c++) @(posedge clk);
        #1;
        check("frame_drained", q_kind.size(), 0);
        for (int g = 0; g < gap_bits; g++) send_bit(1'b1);
    endtask

    task automatic send_good(input logic [DW-1:0] d, input int gap_bits);
        send_frame(d, par_of(d), 1'b1, gap_bits);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc0;
        int ev0;
        int fe0;
        int ov0;
        rst     = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", int'(data_o), 0);
        check("reset_valid", int'(valid_o), 0);
        check("reset_frame_err", int'(frame_err_o), 0);
        check("reset_overrun", int'(overrun_o), 0);
        check("reset_parity_err", int'(parity_err_o), 0);
        rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;

        vc0 = n_valid_cycles;
        send_good(8'h55, 2);
        check("r032_data", int'(data_o), 8'h55);
        check("r032_valid_cycles", n_valid_cycles - vc0, 1);
        check("r032_no_frame_err", n_ferr, 0);

        ev0 = n_events;
        rx_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("r033_no_events", n_events - ev0, 0);
        check("r033_valid", int'(valid_o), 0);
        send_good(8'hC6, 1);
        check("r033_next_frame", int'(data_o), 8'hC6);

        vc0 = n_valid_cycles;
        fe0 = n_ferr;
        send_frame(8'h0F, par_of(8'h0F), 1'b0, 2);
        check("r034_frame_err_count", n_ferr - fe0, 1);
        check("r034_no_valid", n_valid_cycles - vc0, 0);
        send_good(8'h81, 1);
        check("r034_data", int'(data_o), 8'h81);

        send_good(8'h00, 0);
        send_good(8'hFF, 0);
        send_good(8'h6E, 1);
        check("back_to_back_last", int'(data_o), 8'h6E);

        ov0 = n_ovr;
        ready_i = 1'b0;
        send_good(8'hA5, 1);
        send_good(8'h3C, 1);
        check("r035_data", int'(data_o), 8'hA5);
        check("r035_valid", int'(valid_o), 1);
        check("r035_overrun_count", n_ovr - ov0, 1);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        rx_i = 1'(8'h5A >> 4);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("r037_data", int'(data_o), 0);
        check("r037_valid", int'(valid_o), 0);
        check("r037_frame_err", int'(frame_err_o), 0);
        check("r037_overrun", int'(overrun_o), 0);
        check("r037_parity_err", int'(parity_err_o), 0);
        q_kind.delete();
        q_data.delete();
        m_held  = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_good(8'h5A, 1);
        check("r037_next_frame", int'(data_o), 8'h5A);

`ifdef UART_RX_PARITY_EN
        begin
            int pe0;
            pe0 = n_perr;
            vc0 = n_valid_cycles;
            send_frame(8'h03, 1'b1, 1'b1, 1);
            check("r036_parity_err_count", n_perr - pe0, 1);
            check("r036_no_valid", n_valid_cycles - vc0, 0);
            send_frame(8'h03, 1'b0, 1'b1, 1);
            check("r036_data", int'(data_o), 8'h03);
        end
`endif

        repeat (CPB) @(posedge clk);
        #1;
        check("final_queue_empty", q_kind.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
